axi_rdata_return_arbiter: RTL and testbench

- Round-robin arbiter that merges the outputs of `sources` AXI data-latch FIFOs onto one shared return channel toward the interconnect.
- Sits downstream of the per-slave data latches.
- Grants one source per burst and holds the grant until that source's LAST beat has transferred, so bursts are never interleaved.
- Drives a single registered output stage carrying MASTER, ID, DATA, RESP and LAST.

---
 rtl/axi_ret_pkg.sv | 22 ++
 rtl/rr_pick.sv | 37 +++
 rtl/axi_rdata_return_arbiter.sv | 149 ++++++++++++++
 tb/tb_axi_rdata_return_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_ret_pkg.sv
// Shared types and helpers for the AXI return-channel arbiters.
`default_nettype none

package axi_ret_pkg;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  localparam int unsigned ONEHOT_MAX_W = 64;

  // Callers zero-extend narrower vectors; the extra zero bits do not affect the result.
  function automatic logic is_onehot(input logic [ONEHOT_MAX_W-1:0] v);
    return (v != '0) && ((v & (v - ONEHOT_MAX_W'(1))) == '0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first request strictly after ptr, wrapping.
`default_nettype none

module rr_pick #(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  int   cand;
  logic found;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    found   = 1'b0;
    cand    = 0;
    for (int k = 1; k <= int'(N); k++) begin
      cand = (int'(ptr_i) + k) % int'(N);
      if (!found && req_i[cand[IW-1:0]]) begin
        found                = 1'b1;
        gnt_o[cand[IW-1:0]]  = 1'b1;
        idx_o                = cand[IW-1:0];
      end
    end
    valid_o = found;
  end

endmodule

`default_nettype wire

// File: rtl/axi_rdata_return_arbiter.sv
// Burst-granular round-robin merge of data-latch outputs onto one registered return channel.
`default_nettype none

module axi_rdata_return_arbiter
  import axi_ret_pkg::*;
#(
  parameter int unsigned sources    = 4,
  parameter int unsigned masters    = 4,
  parameter int unsigned id_bits    = 2,
  parameter int unsigned data_width = 512
) (
  input  logic                            CLK,
  input  logic                            RESETN,
  input  logic [sources*masters-1:0]      S_MASTER,
  input  logic [sources*id_bits-1:0]      S_ID,
  input  logic [sources*data_width-1:0]   S_DATA,
  input  logic [sources-1:0]              S_LAST,
  input  logic [sources-1:0]              S_VALID,
  output logic [sources-1:0]              S_READY,
  output logic [masters-1:0]              M_MASTER,
  output logic [id_bits-1:0]              M_ID,
  output logic [data_width-1:0]           M_DATA,
  output logic [1:0]                      M_RESP,
  output logic                            M_LAST,
  output logic                            M_VALID,
  input  logic                            M_READY,
  output logic [sources-1:0]              GRANT,
  output logic                            ERR
);

  localparam int unsigned IW = (sources > 1) ? $clog2(sources) : 1;

  state_e                  state_q;
  logic [sources-1:0]      grant_q;
  logic [IW-1:0]           gidx_q;
  logic [IW-1:0]           ptr_q;
  logic                    m_valid_q;
  logic [masters-1:0]      m_master_q;
  logic [id_bits-1:0]      m_id_q;
  logic [data_width-1:0]   m_data_q;
  logic                    m_last_q;
  logic                    err_q;

  logic [sources-1:0]      pick_gnt;
  logic [IW-1:0]           pick_idx;
  logic                    pick_valid;

  logic [masters-1:0]      sel_master;
  logic [id_bits-1:0]      sel_id;
  logic [data_width-1:0]   sel_data;
  logic                    sel_last;
  logic                    sel_valid;
  logic                    out_free;
  logic                    xfer;

  rr_pick #(
    .N (sources)
  ) u_pick (
    .req_i   (S_VALID),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  // grant_q is all-zero in IDLE, so the mux yields no valid beat there.
  always_comb begin
    sel_master = '0;
    sel_id     = '0;
    sel_data   = '0;
    sel_last   = 1'b0;
    for (int i = 0; i < int'(sources); i++) begin
      if (grant_q[i]) begin
        sel_master = S_MASTER[i*masters +: masters];
        sel_id     = S_ID[i*id_bits +: id_bits];
        sel_data   = S_DATA[i*data_width +: data_width];
        sel_last   = S_LAST[i];
      end
    end
  end

  assign sel_valid = |(S_VALID & grant_q);
  assign out_free  = !m_valid_q || M_READY;
  assign xfer      = (state_q == BURST) && sel_valid && out_free;

  assign S_READY  = grant_q & {sources{out_free}};
  assign GRANT    = grant_q;
  assign M_VALID  = m_valid_q;
  assign M_MASTER = m_master_q;
  assign M_ID     = m_id_q;
  assign M_DATA   = m_data_q;
  assign M_LAST   = m_last_q;
  assign M_RESP   = RESP_OKAY;
  assign ERR      = err_q;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      gidx_q     <= '0;
      ptr_q      <= IW'(sources - 1);
      m_valid_q  <= 1'b0;
      m_master_q <= '0;
      m_id_q     <= '0;
      m_data_q   <= '0;
      m_last_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            grant_q <= pick_gnt;
            gidx_q  <= pick_idx;
            state_q <= BURST;
          end
        end
        BURST: begin
          // Grant is held across source stalls until the LAST beat moves.
          if (xfer && sel_last) begin
            ptr_q   <= gidx_q;
            grant_q <= '0;
            state_q <= IDLE;
          end
        end
        default: begin
          grant_q <= '0;
          state_q <= IDLE;
        end
      endcase

      if (xfer) begin
        m_valid_q  <= 1'b1;
        m_master_q <= sel_master;
        m_id_q     <= sel_id;
        m_data_q   <= sel_data;
        m_last_q   <= sel_last;
      end else if (M_READY) begin
        m_valid_q  <= 1'b0;
      end

      if (xfer && !is_onehot(ONEHOT_MAX_W'(sel_master))) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axi_rdata_return_arbiter.sv
// Directed + randomized bench with a transaction-level arbiter model.
`default_nettype none

module tb_axi_rdata_return_arbiter;

  localparam int SRC = 4;
  localparam int MST = 4;
  localparam int IDB = 2;
  localparam int DW  = 512;

  logic                  CLK = 1'b0;
  logic                  RESETN;
  logic [SRC*MST-1:0]    S_MASTER;
  logic [SRC*IDB-1:0]    S_ID;
  logic [SRC*DW-1:0]     S_DATA;
  logic [SRC-1:0]        S_LAST;
  logic [SRC-1:0]        S_VALID;
  logic [SRC-1:0]        S_READY;
  logic [MST-1:0]        M_MASTER;
  logic [IDB-1:0]        M_ID;
  logic [DW-1:0]         M_DATA;
  logic [1:0]            M_RESP;
  logic                  M_LAST;
  logic                  M_VALID;
  logic                  M_READY;
  logic [SRC-1:0]        GRANT;
  logic                  ERR;

  always #5 CLK = ~CLK;

  axi_rdata_return_arbiter dut (
    .CLK      (CLK),
    .RESETN   (RESETN),
    .S_MASTER (S_MASTER),
    .S_ID     (S_ID),
    .S_DATA   (S_DATA),
    .S_LAST   (S_LAST),
    .S_VALID  (S_VALID),
    .S_READY  (S_READY),
    .M_MASTER (M_MASTER),
    .M_ID     (M_ID),
    .M_DATA   (M_DATA),
    .M_RESP   (M_RESP),
    .M_LAST   (M_LAST),
    .M_VALID  (M_VALID),
    .M_READY  (M_READY),
    .GRANT    (GRANT),
    .ERR      (ERR)
  );

  typedef struct packed {
    logic [DW-1:0]  data;
    logic [IDB-1:0] id;
    logic [MST-1:0] master;
    logic           last;
  } beat_t;

  beat_t          srcq [SRC][$];
  logic [SRC-1:0] en;

  // Model: granted source (-1 = none), pointer, output register, sticky error.
  int    mg;
  int    mptr;
  logic  mv;
  beat_t mo;
  logic  merr;

  int             n_vec = 0;
  int             n_err = 0;
  int             delivered;
  int             pushed;
  logic [SRC-1:0] prev_grant;
  int             grant_log [$];
  int             lat;
  int             exp_order [5];

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] r;
    for (int w = 0; w < DW/32; w++) r[w*32 +: 32] = $urandom();
    return r;
  endfunction

  task automatic push_burst(input int s, input int len, input logic [IDB-1:0] id,
                            input logic [MST-1:0] master, input logic [DW-1:0] base,
                            input bit rnd);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.data   = rnd ? rnd_data() : base + DW'(k);
      b.id     = id;
      b.master = master;
      b.last   = (k == len - 1);
      srcq[s].push_back(b);
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < SRC; i++) begin
      if (en[i] && srcq[i].size() > 0) begin
        S_VALID[i]              = 1'b1;
        S_DATA[i*DW +: DW]      = srcq[i][0].data;
        S_ID[i*IDB +: IDB]      = srcq[i][0].id;
        S_MASTER[i*MST +: MST]  = srcq[i][0].master;
        S_LAST[i]               = srcq[i][0].last;
      end else begin
        S_VALID[i]              = 1'b0;
        S_DATA[i*DW +: DW]      = '0;
        S_ID[i*IDB +: IDB]      = '0;
        S_MASTER[i*MST +: MST]  = '0;
        S_LAST[i]               = 1'b0;
      end
    end
  endtask

  task automatic model_reset();
    mg   = -1;
    mptr = SRC - 1;
    mv   = 1'b0;
    mo   = '0;
    merr = 1'b0;
  endtask

  task automatic check_outputs();
    logic [SRC-1:0] eg;
    logic [SRC-1:0] er;
    eg = (mg < 0) ? '0 : (SRC'(1) << mg);
    er = (mg >= 0 && (!mv || M_READY)) ? eg : '0;
    chk("GRANT",    GRANT,    eg);
    chk("S_READY",  S_READY,  er);
    chk("M_VALID",  M_VALID,  mv);
    chk("M_MASTER", M_MASTER, mo.master);
    chk("M_ID",     M_ID,     mo.id);
    chk("M_DATA",   M_DATA,   mo.data);
    chk("M_LAST",   M_LAST,   mo.last);
    chk("M_RESP",   M_RESP,   2'b00);
    chk("ERR",      ERR,      merr);
    if (M_VALID && M_READY) delivered++;
    if (GRANT != '0 && prev_grant == '0) grant_log.push_back(int'(GRANT));
    prev_grant = GRANT;
  endtask

  // One clock of arbitration and output-register behaviour, from the inputs now driven.
  task automatic model_update();
    int   ng;
    int   c;
    logic xf;
    beat_t b;
    ng = mg;
    xf = 1'b0;
    if (mg >= 0) xf = S_VALID[mg] && (!mv || M_READY);
    if (mg < 0) begin
      for (int k = 1; k <= SRC; k++) begin
        c = (mptr + k) % SRC;
        if (ng < 0 && S_VALID[c]) ng = c;
      end
    end
    if (xf) begin
      b  = srcq[mg].pop_front();
      mo = b;
      mv = 1'b1;
      if ($countones(b.master) != 1) merr = 1'b1;
      if (b.last) begin
        mptr = mg;
        ng   = -1;
      end
    end else if (mv && M_READY) begin
      mv = 1'b0;
    end
    mg = ng;
  endtask

  task automatic cycle();
    drive_inputs();
    @(negedge CLK);
    check_outputs();
    if (RESETN) model_update();
    @(posedge CLK);
    #1;
  endtask

  // Called just after a rising edge; asserts reset between edges and checks the immediate effect.
  task automatic async_reset();
    #2;
    RESETN = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < SRC; i++) srcq[i].delete();
    en = '1;
    chk("rst_async_mvalid", M_VALID, 1'b0);
    chk("rst_async_grant",  GRANT,   '0);
    chk("rst_async_sready", S_READY, '0);
    chk("rst_async_err",    ERR,     1'b0);
    chk("rst_async_mdata",  M_DATA,  '0);
    cycle();
    cycle();
    RESETN = 1'b1;
  endtask

  initial begin
    RESETN   = 1'b0;
    M_READY  = 1'b1;
    en       = '1;
    S_VALID  = '0;
    S_DATA   = '0;
    S_ID     = '0;
    S_MASTER = '0;
    S_LAST   = '0;
    prev_grant = '0;
    delivered  = 0;
    pushed     = 0;
    exp_order  = '{1, 2, 4, 8, 1};
    model_reset();

    // Reset, then idle
    cycle();
    cycle();
    RESETN = 1'b1;
    chk("reset_mvalid", M_VALID, 1'b0);
    chk("reset_grant",  GRANT,   '0);
    chk("reset_sready", S_READY, '0);
    chk("reset_err",    ERR,     1'b0);
    for (int i = 0; i < 10; i++) cycle();

    // Single source, 4-beat burst
    delivered = 0;
    lat = -1;
    push_burst(2, 4, 2'd1, 4'b0100, DW'('hA0), 1'b0);
    for (int c = 1; c <= 6; c++) begin
      cycle();
      if (c == 1) chk("single_grant", GRANT, 4'b0100);
      if (lat < 0 && M_VALID) lat = c;
    end
    chk("single_first_latency", lat, 2);
    for (int i = 0; i < 8; i++) cycle();
    chk("single_beats", delivered, 4);
    chk("single_grant_idle", GRANT, '0);

    // Backpressure on beat 2 of a 3-beat burst
    delivered = 0;
    push_burst(3, 3, 2'd2, 4'b1000, DW'('hB0), 1'b0);
    for (int i = 0; i < 3; i++) cycle();
    chk("bp_beat2_loaded", M_DATA, DW'('hB1));
    M_READY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("bp_hold_data",  M_DATA,  DW'('hB1));
      chk("bp_hold_last",  M_LAST,  1'b0);
      chk("bp_sready_low", S_READY, '0);
    end
    M_READY = 1'b1;
    for (int i = 0; i < 6; i++) cycle();
    chk("bp_beats", delivered, 3);

    // Fairness: every source keeps 2-beat bursts pending
    delivered = 0;
    grant_log.delete();
    for (int r = 0; r < 2; r++)
      for (int s = 0; s < SRC; s++)
        push_burst(s, 2, IDB'(s), MST'(1) << s, DW'('h100 + r*16 + s*4), 1'b0);
    for (int i = 0; i < 40; i++) cycle();
    chk("fair_bursts_seen", (grant_log.size() >= 5), 1'b1);
    for (int k = 0; k < 5; k++)
      if (k < grant_log.size()) chk("fair_order", grant_log[k], exp_order[k]);
    chk("fair_beats", delivered, 16);

    // Granted source stalls mid-burst, then reset while waiting
    push_burst(1, 3, 2'd1, 4'b0010, DW'('hC0), 1'b0);
    push_burst(3, 1, 2'd3, 4'b1000, DW'('hD0), 1'b0);
    cycle();
    cycle();
    en[1] = 1'b0;
    for (int i = 0; i < 6; i++) cycle();
    chk("stall_grant_held", GRANT, 4'b0010);
    async_reset();
    push_burst(0, 1, 2'd0, 4'b0001, DW'('hE0), 1'b0);
    push_burst(3, 1, 2'd3, 4'b1000, DW'('hE1), 1'b0);
    cycle();
    chk("post_rst_grant", GRANT, 4'b0001);
    for (int i = 0; i < 8; i++) cycle();

    // Non-one-hot destination
    push_burst(0, 1, 2'd2, 4'b0110, DW'('hEE), 1'b0);
    cycle();
    cycle();
    chk("err_fwd_master", M_MASTER, 4'b0110);
    chk("err_fwd_valid",  M_VALID,  1'b1);
    chk("err_set",        ERR,      1'b1);
    for (int i = 0; i < 5; i++) cycle();
    chk("err_sticky", ERR, 1'b1);

    // Randomized traffic with random source gaps and output backpressure
    delivered = 0;
    pushed    = 0;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(2) == 0) begin
        int s;
        int len;
        s   = $urandom_range(SRC - 1);
        len = $urandom_range(4, 1);
        if (srcq[s].size() < 6) begin
          push_burst(s, len, IDB'($urandom()),
                     ($urandom_range(7) == 0) ? MST'($urandom()) : (MST'(1) << $urandom_range(MST - 1)),
                     '0, 1'b1);
          pushed += len;
        end
      end
      for (int k = 0; k < SRC; k++) en[k] = ($urandom_range(3) != 0);
      M_READY = ($urandom_range(3) != 0);
      cycle();
    end
    en = '1;
    M_READY = 1'b1;
    for (int i = 0; i < 100; i++) cycle();
    chk("rand_beats", delivered, pushed);
    chk("rand_queues_empty", srcq[0].size() + srcq[1].size() + srcq[2].size() + srcq[3].size(), 0);

    async_reset();
    cycle();
    chk("final_err_cleared", ERR, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
